// File: rtl/background_index_arbiter_if.sv
// rtl/background_index_arbiter_if.sv - requester and s1 memory signal bundle for background_index_arbiter
interface background_index_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
);
  logic              rnd_req;
  logic [ADDR_W-1:0] rnd_addr;
  logic              rnd_ready;
  logic [DATA_W-1:0] rnd_rdata;
  logic              rnd_rvalid;

  logic              host_req;
  logic              host_write;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic [BE_W-1:0]   host_be;
  logic              host_ready;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;

  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_clken;
  logic              mem_debugaccess;
  logic              mem_reset_req;
  logic [DATA_W-1:0] mem_readdata;

  modport slave (
    input  rnd_req, rnd_addr,
    input  host_req, host_write, host_addr, host_wdata, host_be,
    input  mem_readdata,
    output rnd_ready, rnd_rdata, rnd_rvalid,
    output host_ready, host_rdata, host_rvalid,
    output mem_address, mem_chipselect, mem_write, mem_writedata, mem_byteenable,
    output mem_clken, mem_debugaccess, mem_reset_req
  );

  modport master (
    output rnd_req, rnd_addr,
    output host_req, host_write, host_addr, host_wdata, host_be,
    output mem_readdata,
    input  rnd_ready, rnd_rdata, rnd_rvalid,
    input  host_ready, host_rdata, host_rvalid,
    input  mem_address, mem_chipselect, mem_write, mem_writedata, mem_byteenable,
    input  mem_clken, mem_debugaccess, mem_reset_req
  );
endinterface

// File: rtl/background_index_arbiter.sv
// rtl/background_index_arbiter.sv - render/host arbiter for the background_index s1 memory port
module background_index_arbiter #(
  parameter int ADDR_W       = 6,
  parameter int DATA_W       = 32,
  parameter int BE_W         = 4,
  parameter int READ_LATENCY = 1,
  parameter int MAX_STREAK   = 4
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  background_index_arbiter_if.slave bus
);
  localparam int STREAK_W  = $clog2(MAX_STREAK + 1);
  localparam int TAG_DEPTH = 1 + READ_LATENCY;

  logic                 host_win;
  logic                 rnd_acc;
  logic                 push_valid;
  logic [STREAK_W-1:0]  streak;
  logic [TAG_DEPTH-1:0] tag_valid;
  logic [TAG_DEPTH-1:0] tag_host;
  logic                 rnd_rvalid_w;
  logic                 host_rvalid_w;
  logic [DATA_W-1:0]    rnd_rdata_q;
  logic [DATA_W-1:0]    host_rdata_q;
  logic [ADDR_W-1:0]    cmd_address;
  logic                 cmd_cs;
  logic                 cmd_write;
  logic [DATA_W-1:0]    cmd_wdata;
  logic [BE_W-1:0]      cmd_be;
  logic                 clken_q;

  // Gating with reset keeps requests from being accepted while in reset.
  always_comb begin
    host_win   = reset_reset_n & bus.host_req &
                 (~bus.rnd_req | (streak == STREAK_W'(MAX_STREAK)));
    rnd_acc    = reset_reset_n & bus.rnd_req & ~host_win;
    push_valid = rnd_acc | (host_win & ~bus.host_write);
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      streak <= '0;
    end else if (!bus.host_req || host_win) begin
      streak <= '0;
    end else if (rnd_acc && streak != STREAK_W'(MAX_STREAK)) begin
      streak <= streak + 1'b1;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      cmd_address <= '0;
      cmd_cs      <= 1'b0;
      cmd_write   <= 1'b0;
      cmd_wdata   <= '0;
      cmd_be      <= '0;
      clken_q     <= 1'b0;
    end else begin
      clken_q <= 1'b1;
      if (host_win) begin
        cmd_address <= bus.host_addr;
        cmd_cs      <= 1'b1;
        cmd_write   <= bus.host_write;
        cmd_wdata   <= bus.host_wdata;
        cmd_be      <= bus.host_be;
      end else if (rnd_acc) begin
        cmd_address <= bus.rnd_addr;
        cmd_cs      <= 1'b1;
        cmd_write   <= 1'b0;
        cmd_be      <= '1;
      end else begin
        cmd_cs    <= 1'b0;
        cmd_write <= 1'b0;
      end
    end
  end

  // Tag pipe: oldest entry lines up with mem_readdata for the matching read.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      tag_valid <= '0;
      tag_host  <= '0;
    end else begin
      tag_valid <= {tag_valid[TAG_DEPTH-2:0], push_valid};
      tag_host  <= {tag_host[TAG_DEPTH-2:0], host_win};
    end
  end

  always_comb begin
    rnd_rvalid_w  = tag_valid[READ_LATENCY] & ~tag_host[READ_LATENCY];
    host_rvalid_w = tag_valid[READ_LATENCY] &  tag_host[READ_LATENCY];
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      rnd_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      if (rnd_rvalid_w)  rnd_rdata_q  <= bus.mem_readdata;
      if (host_rvalid_w) host_rdata_q <= bus.mem_readdata;
    end
  end

  // Read data passes straight through on the pulse so it lands 1+READ_LATENCY after accept.
  assign bus.rnd_ready       = rnd_acc;
  assign bus.host_ready      = host_win;
  assign bus.rnd_rvalid      = rnd_rvalid_w;
  assign bus.host_rvalid     = host_rvalid_w;
  assign bus.rnd_rdata       = rnd_rvalid_w  ? bus.mem_readdata : rnd_rdata_q;
  assign bus.host_rdata      = host_rvalid_w ? bus.mem_readdata : host_rdata_q;
  assign bus.mem_address     = cmd_address;
  assign bus.mem_chipselect  = cmd_cs;
  assign bus.mem_write       = cmd_write;
  assign bus.mem_writedata   = cmd_wdata;
  assign bus.mem_byteenable  = cmd_be;
  assign bus.mem_clken       = clken_q;
  assign bus.mem_debugaccess = 1'b0;
  assign bus.mem_reset_req   = 1'b0;
endmodule

// File: tb/tb_background_index_arbiter.sv
// tb/tb_background_index_arbiter.sv - directed bench for background_index_arbiter (RL=1 and RL=2 instances)
module tb_background_index_arbiter;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   n_rnd;
  int   n_host;

  background_index_arbiter_if #(.ADDR_W(6), .DATA_W(32), .BE_W(4)) ifa ();
  background_index_arbiter_if #(.ADDR_W(6), .DATA_W(32), .BE_W(4)) ifb ();

  background_index_arbiter #(.READ_LATENCY(1), .MAX_STREAK(4)) dut_a (
    .clk_clk(clk), .reset_reset_n(rst_n), .bus(ifa)
  );
  background_index_arbiter #(.READ_LATENCY(2), .MAX_STREAK(4)) dut_b (
    .clk_clk(clk), .reset_reset_n(rst_n), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // s1 memory models: RL=1 for instance A, RL=2 for instance B
  logic [31:0] mem_a [64];
  logic [31:0] mem_b [64];
  logic [31:0] rd_a;
  logic [31:0] rd_b1;
  logic [31:0] rd_b2;

  always @(posedge clk) begin
    if (ifa.mem_clken && ifa.mem_chipselect) begin
      if (ifa.mem_write) begin
        for (int b = 0; b < 4; b++)
          if (ifa.mem_byteenable[b]) mem_a[ifa.mem_address][b*8 +: 8] <= ifa.mem_writedata[b*8 +: 8];
      end else begin
        rd_a <= mem_a[ifa.mem_address];
      end
    end
  end

  always @(posedge clk) begin
    if (ifb.mem_clken && ifb.mem_chipselect) begin
      if (ifb.mem_write) begin
        for (int b = 0; b < 4; b++)
          if (ifb.mem_byteenable[b]) mem_b[ifb.mem_address][b*8 +: 8] <= ifb.mem_writedata[b*8 +: 8];
      end else begin
        rd_b1 <= mem_b[ifb.mem_address];
      end
    end
    rd_b2 <= rd_b1;
  end

  assign ifa.mem_readdata = rd_a;
  assign ifb.mem_readdata = rd_b2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [5:0]  pa_addr [4];
  logic [31:0] pa_data [4];
  logic [5:0]  pb_addr [4];
  logic [31:0] pb_data [4];

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    ifa.rnd_req = 0; ifa.rnd_addr = 0; ifa.host_req = 0; ifa.host_write = 0;
    ifa.host_addr = 0; ifa.host_wdata = 0; ifa.host_be = 0;
    ifb.rnd_req = 0; ifb.rnd_addr = 0; ifb.host_req = 0; ifb.host_write = 0;
    ifb.host_addr = 0; ifb.host_wdata = 0; ifb.host_be = 0;
    pa_addr[0] = 6'd5;  pa_data[0] = 32'hA5A50005;
    pa_addr[1] = 6'd9;  pa_data[1] = 32'h99990009;
    pa_addr[2] = 6'd63; pa_data[2] = 32'h11111111;
    pa_addr[3] = 6'd7;  pa_data[3] = 32'h77770007;
    for (int i = 0; i < 4; i++) begin
      pb_addr[i] = 6'(i + 1);
      pb_data[i] = 32'hB0000001 + 32'(i);
    end

    tick(); tick(); #1;
    chk("rst_cs", ifa.mem_chipselect, 1'b0);
    chk("rst_clken", ifa.mem_clken, 1'b0);
    chk("rst_addr", ifa.mem_address, 6'd0);
    chk("rst_rvalid", ifa.rnd_rvalid, 1'b0);
    rst_n = 1'b1;
    tick(); #1;
    chk("clken_after_rst", ifa.mem_clken, 1'b1);

    // Preload both memories through the host write path
    for (int i = 0; i < 4; i++) begin
      ifa.host_req = 1; ifa.host_write = 1; ifa.host_be = 4'hF;
      ifa.host_addr = pa_addr[i]; ifa.host_wdata = pa_data[i];
      ifb.host_req = 1; ifb.host_write = 1; ifb.host_be = 4'hF;
      ifb.host_addr = pb_addr[i]; ifb.host_wdata = pb_data[i];
      tick();
    end
    ifa.host_req = 0; ifa.host_write = 0;
    ifb.host_req = 0; ifb.host_write = 0;
    tick(); tick();

    // 1: single render read
    ifa.rnd_req = 1; ifa.rnd_addr = 6'd5; #1;
    chk("t1_rnd_ready", ifa.rnd_ready, 1'b1);
    chk("t1_host_ready", ifa.host_ready, 1'b0);
    tick(); ifa.rnd_req = 0; #1;
    chk("t1_cs", ifa.mem_chipselect, 1'b1);
    chk("t1_addr", ifa.mem_address, 6'd5);
    chk("t1_write", ifa.mem_write, 1'b0);
    chk("t1_be", ifa.mem_byteenable, 4'hF);
    chk("t1_rvalid_early", ifa.rnd_rvalid, 1'b0);
    tick(); #1;
    chk("t1_rvalid", ifa.rnd_rvalid, 1'b1);
    chk("t1_rdata", ifa.rnd_rdata, 32'hA5A50005);
    chk("t1_host_rvalid", ifa.host_rvalid, 1'b0);
    tick(); #1;
    chk("t1_rvalid_pulse", ifa.rnd_rvalid, 1'b0);
    chk("t1_rdata_hold", ifa.rnd_rdata, 32'hA5A50005);
    chk("t1_cs_idle", ifa.mem_chipselect, 1'b0);

    // 2: simultaneous requests, streak 0
    ifa.rnd_req = 1; ifa.rnd_addr = 6'd7;
    ifa.host_req = 1; ifa.host_write = 0; ifa.host_addr = 6'd9; ifa.host_be = 4'hF; #1;
    chk("t2_rnd_ready", ifa.rnd_ready, 1'b1);
    chk("t2_host_wait", ifa.host_ready, 1'b0);
    tick(); ifa.rnd_req = 0; #1;
    chk("t2_host_ready", ifa.host_ready, 1'b1);
    chk("t2_rnd_idle", ifa.rnd_ready, 1'b0);
    tick(); ifa.host_req = 0; #1;
    chk("t2_rnd_rvalid", ifa.rnd_rvalid, 1'b1);
    chk("t2_rnd_rdata", ifa.rnd_rdata, 32'h77770007);
    chk("t2_host_rvalid_early", ifa.host_rvalid, 1'b0);
    tick(); #1;
    chk("t2_host_rvalid", ifa.host_rvalid, 1'b1);
    chk("t2_host_rdata", ifa.host_rdata, 32'h99990009);
    chk("t2_rnd_rvalid_off", ifa.rnd_rvalid, 1'b0);
    tick();

    // 3: sustained contention, 4 render : 1 host
    n_rnd = 0; n_host = 0;
    ifa.rnd_req = 1; ifa.rnd_addr = 6'd7;
    ifa.host_req = 1; ifa.host_write = 0; ifa.host_addr = 6'd9;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("t3_host_grant", ifa.host_ready, (i % 5) == 4);
      chk("t3_rnd_grant", ifa.rnd_ready, (i % 5) != 4);
      if (ifa.rnd_ready) n_rnd++;
      if (ifa.host_ready) n_host++;
      tick();
    end
    ifa.rnd_req = 0; ifa.host_req = 0;
    chk("t3_rnd_count", n_rnd, 16);
    chk("t3_host_count", n_host, 4);
    tick(); tick(); tick();

    // 4: partial write then read-after-write
    ifa.host_req = 1; ifa.host_write = 1; ifa.host_addr = 6'd63;
    ifa.host_wdata = 32'hDEADBEEF; ifa.host_be = 4'b0011; #1;
    chk("t4_wr_ready", ifa.host_ready, 1'b1);
    tick(); ifa.host_write = 0; ifa.host_be = 4'hF; #1;
    chk("t4_cs", ifa.mem_chipselect, 1'b1);
    chk("t4_write", ifa.mem_write, 1'b1);
    chk("t4_be", ifa.mem_byteenable, 4'b0011);
    chk("t4_wdata", ifa.mem_writedata, 32'hDEADBEEF);
    chk("t4_addr", ifa.mem_address, 6'd63);
    chk("t4_rd_ready", ifa.host_ready, 1'b1);
    tick(); ifa.host_req = 0; #1;
    chk("t4_rd_cmd_write", ifa.mem_write, 1'b0);
    chk("t4_no_wr_rvalid", ifa.host_rvalid, 1'b0);
    tick(); #1;
    chk("t4_rvalid", ifa.host_rvalid, 1'b1);
    chk("t4_rdata", ifa.host_rdata, 32'h1111BEEF);
    tick();

    // 5: alternating back-to-back accepts on the RL=2 instance
    ifb.rnd_req = 1; ifb.rnd_addr = 6'd1; #1;
    chk("t5_r1_ready", ifb.rnd_ready, 1'b1);
    tick(); ifb.rnd_req = 0;
    ifb.host_req = 1; ifb.host_write = 0; ifb.host_be = 4'hF; ifb.host_addr = 6'd2; #1;
    chk("t5_h2_ready", ifb.host_ready, 1'b1);
    chk("t5_c1_rvalid", ifb.rnd_rvalid | ifb.host_rvalid, 1'b0);
    tick(); ifb.host_req = 0; ifb.rnd_req = 1; ifb.rnd_addr = 6'd3; #1;
    chk("t5_r3_ready", ifb.rnd_ready, 1'b1);
    chk("t5_c2_rvalid", ifb.rnd_rvalid | ifb.host_rvalid, 1'b0);
    tick(); ifb.rnd_req = 0; ifb.host_req = 1; ifb.host_addr = 6'd4; #1;
    chk("t5_h4_ready", ifb.host_ready, 1'b1);
    chk("t5_c3_rnd_rvalid", ifb.rnd_rvalid, 1'b1);
    chk("t5_c3_rnd_rdata", ifb.rnd_rdata, 32'hB0000001);
    chk("t5_c3_host_rvalid", ifb.host_rvalid, 1'b0);
    tick(); ifb.host_req = 0; #1;
    chk("t5_c4_host_rvalid", ifb.host_rvalid, 1'b1);
    chk("t5_c4_host_rdata", ifb.host_rdata, 32'hB0000002);
    chk("t5_c4_rnd_rvalid", ifb.rnd_rvalid, 1'b0);
    tick(); #1;
    chk("t5_c5_rnd_rvalid", ifb.rnd_rvalid, 1'b1);
    chk("t5_c5_rnd_rdata", ifb.rnd_rdata, 32'hB0000003);
    chk("t5_c5_host_rvalid", ifb.host_rvalid, 1'b0);
    tick(); #1;
    chk("t5_c6_host_rvalid", ifb.host_rvalid, 1'b1);
    chk("t5_c6_host_rdata", ifb.host_rdata, 32'hB0000004);
    chk("t5_c6_rnd_rvalid", ifb.rnd_rvalid, 1'b0);
    tick(); #1;
    chk("t5_c7_rvalid", ifb.rnd_rvalid | ifb.host_rvalid, 1'b0);
    chk("t5_c7_host_hold", ifb.host_rdata, 32'hB0000004);

    // 6: reset while a render read is in flight
    ifa.rnd_req = 1; ifa.rnd_addr = 6'd5; #1;
    chk("t6_rnd_ready", ifa.rnd_ready, 1'b1);
    tick(); rst_n = 1'b0; #1;
    chk("t6_ready_in_reset", ifa.rnd_ready, 1'b0);
    chk("t6_host_ready_in_reset", ifa.host_ready, 1'b0);
    tick(); rst_n = 1'b1; ifa.rnd_req = 0; #1;
    chk("t6_cs_rst", ifa.mem_chipselect, 1'b0);
    chk("t6_clken_rst", ifa.mem_clken, 1'b0);
    chk("t6_addr_rst", ifa.mem_address, 6'd0);
    chk("t6_rvalid_rst", ifa.rnd_rvalid, 1'b0);
    chk("t6_rdata_rst", ifa.rnd_rdata, 32'd0);
    chk("t6_host_rvalid_rst", ifa.host_rvalid, 1'b0);
    tick(); #1;
    chk("t6_clken_release", ifa.mem_clken, 1'b1);
    chk("t6_rvalid_c3", ifa.rnd_rvalid, 1'b0);
    tick(); #1;
    chk("t6_rvalid_c4", ifa.rnd_rvalid, 1'b0);
    chk("t6_debugaccess", ifa.mem_debugaccess, 1'b0);
    chk("t6_reset_req", ifa.mem_reset_req, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
